tri_tile_dispatch: RTL and testbench
====================================

Name: tri_tile_dispatch

Overview:
- Transmitter feeding the tile rasterizer's triangle input.
- Accepts one screen-space triangle (three 3D vertices plus color), computes its tile bounding box, and emits one (v0, v1, v2, metadata) beat per overlapped 32x32 tile over a valid/ready handshake.
- Beats are issued in raster order.
- Sits between the geometry/setup stage and the rasterizer.

Parameters:
- TILE_SHIFT, 5, log2 of tile width in pixels (32).
- TILE_COLUMNS, 20, tiles per row (640 px).
- TILE_ROWS, 15, tile rows (480 px).
- CULL_DEGENERATE, 1, when 1 drop zero-area triangles.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- tri_vld_in  input  1  upstream triangle valid.
- tri_rdy_out  output  1  dispatcher can accept a triangle.
- v0_in, v1_in, v2_in  input  28 each  vertex {x[9:0], y[9:0], z[7:0]}.
- color_in  input  4  triangle color.
- ready_in  input  1  rasterizer ready for next tile beat.
- vld_out  output  1  tile beat valid.
- v0_out, v1_out, v2_out  output  28 each  captured vertices, unchanged.
- metadata_out  output  16  {color[3:0], padding 3'b000, tile_y[3:0], tile_x[4:0]}.
- busy  output  1  high in any state other than IDLE.
- tiles_sent  output  16  count of accepted tile beats since reset; wraps at 2^16.

Behaviour:
- Interface timing:
  - Single clock.
  - Synchronous active-high reset sampled on posedge clk.
  - All outputs are registered.
- Reset values:
  - Reset forces IDLE.
  - tri_rdy_out=1 after the reset edge.
  - vld_out=0, busy=0, tiles_sent=0.
  - v*_out=0, metadata_out=0.
- States: IDLE, SETUP, EMIT.
- IDLE:
  - tri_rdy_out=1.
  - On tri_vld_in && tri_rdy_out, capture v0..v2 and color, then go to SETUP.
  - tri_rdy_out=0 in every other state; the upstream handshake is accepted only in IDLE.
- SETUP (1 cycle):
  - Bounding box: min/max of x and y over the three vertices, unsigned 10-bit.
  - Tile indices: tx_min=min_x>>TILE_SHIFT, tx_max=max_x>>TILE_SHIFT; same for y.
  - tx_max clamps to TILE_COLUMNS-1 and ty_max clamps to TILE_ROWS-1.
  - Off-screen: if min_x>=640 or min_y>=480 (i.e. tx_min>=TILE_COLUMNS or ty_min>=TILE_ROWS), drop the triangle and return to IDLE.
  - Degenerate: area = (x1-x0)*(y2-y0) - (x2-x0)*(y1-y0), computed as signed 22-bit from 11-bit signed differences. If CULL_DEGENERATE=1 and area==0, drop and return to IDLE.
  - Otherwise load cur_tx=tx_min, cur_ty=ty_min and go to EMIT.
- EMIT:
  - vld_out=1 and busy=1.
  - metadata_out carries cur_ty/cur_tx; v*_out carry the captured vertices.
  - All outputs hold stable while vld_out && !ready_in.
  - On vld_out && ready_in:
    - tiles_sent increments.
    - If cur_tx<tx_max: cur_tx+1.
    - Else if cur_ty<ty_max: cur_tx=tx_min, cur_ty+1.
    - Else (last tile): vld_out=0 next cycle, go to IDLE.
  - vld_out never deasserts without a handshake, except on reset.
- Latency:
  - Triangle handshake in cycle N → SETUP in N+1 → first vld_out=1 in N+2, assuming no cull.
  - Back-to-back tiles issue one per cycle when ready_in is held high.
  - After the last tile handshake in cycle M, tri_rdy_out=1 in M+1.
  - A triangle covering k tiles occupies ≥k+2 cycles between accepts.
- Boundary conditions:
  - Single-tile bbox: exactly one beat.
  - x coordinates 640..1023 clamp to column 19; y coordinates 480..1023 clamp to row 14.
  - Vertex order does not affect bbox or emitted tiles.
  - Reset mid-EMIT aborts the triangle: vld_out=0 after the reset edge, tiles_sent=0, and no further beats are emitted for it.
  - tri_vld_in while busy is ignored (no capture).

Test Plan:
- Single tile: v0=(10,10,0), v1=(20,10,0), v2=(10,20,0), color=5, ready_in=1 → exactly one beat, metadata_out=16'h5000 (tile 0,0), vld_out at N+2, tiles_sent=1, tri_rdy_out=1 again.
- 2x2 span: v0=(20,20), v1=(40,20), v2=(20,40), color=3 → beats in order (tx,ty)=(0,0),(1,0),(0,1),(1,1), one per cycle, tiles_sent=4.
- Backpressure: same 2x2 triangle with ready_in low for 3 cycles at beat 2 → beat 2 held stable (metadata and vertices unchanged) for all 3 cycles; the sequence is unaltered and no beat is duplicated or lost.
- Clamp/off-screen: triangle (600,460),(1000,470),(620,1000) → tiles tx 18..19, ty 14 only (2 beats). Triangle with all x≥700 → 0 beats, tri_rdy_out high 2 cycles after accept.
- Degenerate: collinear (0,0),(64,64),(128,128), CULL_DEGENERATE=1 → 0 beats, tiles_sent unchanged. With CULL_DEGENERATE=0 → 25 beats (5x5 tiles).
- Reset mid-EMIT: rst=1 for 1 cycle during beat 2 of the 2x2 case → vld_out=0, tiles_sent=0, tri_rdy_out=1 after the edge; a new triangle is then processed normally.

Source files
------------

// File: rtl/tri_tile_dispatch.sv
// tri_tile_dispatch: accepts one screen-space triangle, works out which
// 32x32 tiles its bounding box overlaps, and streams one beat per tile
// (raster order) to the tile rasterizer over a valid/ready handshake.
module tri_tile_dispatch #(
  parameter int TILE_SHIFT      = 5,
  parameter int TILE_COLUMNS    = 20,
  parameter int TILE_ROWS       = 15,
  parameter bit CULL_DEGENERATE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tri_vld_in,
  output logic        tri_rdy_out,
  input  logic [27:0] v0_in,
  input  logic [27:0] v1_in,
  input  logic [27:0] v2_in,
  input  logic [3:0]  color_in,
  input  logic        ready_in,
  output logic        vld_out,
  output logic [27:0] v0_out,
  output logic [27:0] v1_out,
  output logic [27:0] v2_out,
  output logic [15:0] metadata_out,
  output logic        busy,
  output logic [15:0] tiles_sent
);

  localparam logic [9:0] COL_COUNT = 10'(TILE_COLUMNS);
  localparam logic [9:0] COL_LAST  = 10'(TILE_COLUMNS - 1);
  localparam logic [9:0] ROW_COUNT = 10'(TILE_ROWS);
  localparam logic [9:0] ROW_LAST  = 10'(TILE_ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  state_t      state_q, state_d;
  logic [27:0] v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic [3:0]  color_q, color_d;
  logic [4:0]  tx_min_q, tx_min_d, tx_max_q, tx_max_d, cur_tx_q, cur_tx_d;
  logic [3:0]  ty_max_q, ty_max_d, cur_ty_q, cur_ty_d;
  logic        vld_q, vld_d, rdy_q, rdy_d, busy_q, busy_d;
  logic [15:0] tiles_q, tiles_d;

  // Bounding-box / culling terms, all derived from the captured vertices.
  logic [9:0]         x0_s, x1_s, x2_s, y0_s, y1_s, y2_s;
  logic [9:0]         min_x_s, max_x_s, min_y_s, max_y_s;
  logic [9:0]         tx_lo_s, tx_hi_s, ty_lo_s, ty_hi_s;
  logic [4:0]         tx_min_s, tx_max_s;
  logic [3:0]         ty_min_s, ty_max_s;
  logic signed [10:0] dx1_s, dy1_s, dx2_s, dy2_s;
  logic signed [21:0] ex1_s, ey1_s, ex2_s, ey2_s, area_s;
  logic               off_screen_s, degenerate_s;

  // Tile bounding box, clamping and cull decisions for the SETUP cycle.
  always_comb begin
    x0_s = v0_q[27:18];
    x1_s = v1_q[27:18];
    x2_s = v2_q[27:18];
    y0_s = v0_q[17:8];
    y1_s = v1_q[17:8];
    y2_s = v2_q[17:8];

    min_x_s = min3(x0_s, x1_s, x2_s);
    max_x_s = max3(x0_s, x1_s, x2_s);
    min_y_s = min3(y0_s, y1_s, y2_s);
    max_y_s = max3(y0_s, y1_s, y2_s);

    tx_lo_s = min_x_s >> TILE_SHIFT;
    tx_hi_s = max_x_s >> TILE_SHIFT;
    ty_lo_s = min_y_s >> TILE_SHIFT;
    ty_hi_s = max_y_s >> TILE_SHIFT;

    off_screen_s = (tx_lo_s >= COL_COUNT) || (ty_lo_s >= ROW_COUNT);
    tx_min_s     = tx_lo_s[4:0];
    ty_min_s     = ty_lo_s[3:0];

    // Coordinates past the right/bottom edge still land in the last column/row.
    if (tx_hi_s > COL_LAST) begin
      tx_max_s = COL_LAST[4:0];
    end else begin
      tx_max_s = tx_hi_s[4:0];
    end
    if (ty_hi_s > ROW_LAST) begin
      ty_max_s = ROW_LAST[3:0];
    end else begin
      ty_max_s = ty_hi_s[3:0];
    end

    // Twice the signed area; the 22-bit result cannot overflow for 10-bit inputs.
    dx1_s  = $signed({1'b0, x1_s}) - $signed({1'b0, x0_s});
    dy1_s  = $signed({1'b0, y1_s}) - $signed({1'b0, y0_s});
    dx2_s  = $signed({1'b0, x2_s}) - $signed({1'b0, x0_s});
    dy2_s  = $signed({1'b0, y2_s}) - $signed({1'b0, y0_s});
    ex1_s  = {{11{dx1_s[10]}}, dx1_s};
    ey1_s  = {{11{dy1_s[10]}}, dy1_s};
    ex2_s  = {{11{dx2_s[10]}}, dx2_s};
    ey2_s  = {{11{dy2_s[10]}}, dy2_s};
    area_s = (ex1_s * ey2_s) - (ex2_s * ey1_s);

    degenerate_s = (CULL_DEGENERATE == 1'b1) && (area_s == 22'sd0);
  end

  // Next-state logic: triangle capture, setup, and tile walk in raster order.
  always_comb begin
    state_d  = state_q;
    v0_d     = v0_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    color_d  = color_q;
    tx_min_d = tx_min_q;
    tx_max_d = tx_max_q;
    ty_max_d = ty_max_q;
    cur_tx_d = cur_tx_q;
    cur_ty_d = cur_ty_q;
    vld_d    = vld_q;
    rdy_d    = rdy_q;
    busy_d   = busy_q;
    tiles_d  = tiles_q;

    case (state_q)
      ST_IDLE: begin
        if (tri_vld_in && rdy_q) begin
          v0_d    = v0_in;
          v1_d    = v1_in;
          v2_d    = v2_in;
          color_d = color_in;
          state_d = ST_SETUP;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
          vld_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          vld_d   = 1'b0;
        end
      end

      ST_SETUP: begin
        if (off_screen_s || degenerate_s) begin
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
          vld_d   = 1'b0;
        end else begin
          tx_min_d = tx_min_s;
          tx_max_d = tx_max_s;
          ty_max_d = ty_max_s;
          cur_tx_d = tx_min_s;
          cur_ty_d = ty_min_s;
          state_d  = ST_EMIT;
          rdy_d    = 1'b0;
          busy_d   = 1'b1;
          vld_d    = 1'b1;
        end
      end

      ST_EMIT: begin
        // Without a handshake every output register simply holds.
        if (vld_q && ready_in) begin
          tiles_d = tiles_q + 16'd1;
          if (cur_tx_q < tx_max_q) begin
            cur_tx_d = cur_tx_q + 5'd1;
          end else if (cur_ty_q < ty_max_q) begin
            cur_tx_d = tx_min_q;
            cur_ty_d = cur_ty_q + 4'd1;
          end else begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end

      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
        rdy_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      v0_q     <= 28'd0;
      v1_q     <= 28'd0;
      v2_q     <= 28'd0;
      color_q  <= 4'd0;
      tx_min_q <= 5'd0;
      tx_max_q <= 5'd0;
      ty_max_q <= 4'd0;
      cur_tx_q <= 5'd0;
      cur_ty_q <= 4'd0;
      vld_q    <= 1'b0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      tiles_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      v0_q     <= v0_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      color_q  <= color_d;
      tx_min_q <= tx_min_d;
      tx_max_q <= tx_max_d;
      ty_max_q <= ty_max_d;
      cur_tx_q <= cur_tx_d;
      cur_ty_q <= cur_ty_d;
      vld_q    <= vld_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      tiles_q  <= tiles_d;
    end
  end

  assign tri_rdy_out  = rdy_q;
  assign vld_out      = vld_q;
  assign busy         = busy_q;
  assign tiles_sent   = tiles_q;
  assign v0_out       = v0_q;
  assign v1_out       = v1_q;
  assign v2_out       = v2_q;
  assign metadata_out = {color_q, 3'b000, cur_ty_q, cur_tx_q};

endmodule

// File: tb/tb_tri_tile_dispatch.sv
// Testbench for tri_tile_dispatch: two instances (degenerate culling on and
// off) share one stimulus stream; each is compared to a tile-list model.
module tb_tri_tile_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        tri_vld_in;
  logic        ready_in;
  logic [27:0] v0_in, v1_in, v2_in;
  logic [3:0]  color_in;

  logic        rdy_o  [2];
  logic        vld_o  [2];
  logic        busy_o [2];
  logic [27:0] v0_o   [2];
  logic [27:0] v1_o   [2];
  logic [27:0] v2_o   [2];
  logic [15:0] meta_o [2];
  logic [15:0] tiles_o[2];

  int checks   = 0;
  int failures = 0;

  // Expected tile beats per instance: index 0 culls degenerates, 1 does not.
  logic [15:0] exp_meta[2][300];
  int          exp_n[2];

  always #5 clk = ~clk;

  tri_tile_dispatch #(.CULL_DEGENERATE(1'b1)) dut (
    .clk(clk), .rst(rst), .tri_vld_in(tri_vld_in), .tri_rdy_out(rdy_o[0]),
    .v0_in(v0_in), .v1_in(v1_in), .v2_in(v2_in), .color_in(color_in),
    .ready_in(ready_in), .vld_out(vld_o[0]), .v0_out(v0_o[0]), .v1_out(v1_o[0]),
    .v2_out(v2_o[0]), .metadata_out(meta_o[0]), .busy(busy_o[0]),
    .tiles_sent(tiles_o[0])
  );

  tri_tile_dispatch #(.CULL_DEGENERATE(1'b0)) dut_nc (
    .clk(clk), .rst(rst), .tri_vld_in(tri_vld_in), .tri_rdy_out(rdy_o[1]),
    .v0_in(v0_in), .v1_in(v1_in), .v2_in(v2_in), .color_in(color_in),
    .ready_in(ready_in), .vld_out(vld_o[1]), .v0_out(v0_o[1]), .v1_out(v1_o[1]),
    .v2_out(v2_o[1]), .metadata_out(meta_o[1]), .busy(busy_o[1]),
    .tiles_sent(tiles_o[1])
  );

  function automatic logic [27:0] vtx(input int x, input int y, input int z);
    return {10'(x), 10'(y), 8'(z)};
  endfunction

  // Reference: list of tiles a triangle covers, from plain integer geometry.
  task automatic build_model(input logic [27:0] a, input logic [27:0] b,
                             input logic [27:0] c, input logic [3:0] col);
    int xs[3], ys[3];
    int mnx, mxx, mny, mxy, area, tx0, tx1, ty0, ty1;
    logic [27:0] v[3];
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < 3; i++) begin
      xs[i] = int'(v[i][27:18]);
      ys[i] = int'(v[i][17:8]);
    end
    mnx = 2000; mxx = -1; mny = 2000; mxy = -1;
    for (int i = 0; i < 3; i++) begin
      if (xs[i] < mnx) mnx = xs[i];
      if (xs[i] > mxx) mxx = xs[i];
      if (ys[i] < mny) mny = ys[i];
      if (ys[i] > mxy) mxy = ys[i];
    end
    area = (xs[1] - xs[0]) * (ys[2] - ys[0]) - (xs[2] - xs[0]) * (ys[1] - ys[0]);
    tx0 = mnx / 32; tx1 = mxx / 32; ty0 = mny / 32; ty1 = mxy / 32;
    if (tx1 > 19) tx1 = 19;
    if (ty1 > 14) ty1 = 14;
    for (int d = 0; d < 2; d++) begin
      exp_n[d] = 0;
      if (mnx < 640 && mny < 480 && !(d == 0 && area == 0)) begin
        for (int ty = ty0; ty <= ty1; ty++) begin
          for (int tx = tx0; tx <= tx1; tx++) begin
            exp_meta[d][exp_n[d]] = {col, 3'b000, 4'(ty), 5'(tx)};
            exp_n[d]++;
          end
        end
      end
    end
  endtask

  // Send one triangle and follow both instances until they are idle again.
  task automatic run_tri(input logic [27:0] a, input logic [27:0] b, input logic [27:0] c,
                         input logic [3:0] col, input int stall_at, input int stall_len,
                         input bit rnd_ready);
    int          got[2], t0[2];
    logic [15:0] prev_meta[2];
    bit          stalled_prev[2], idle_next[2];
    int          stall_cnt, cyc, n;
    logic        r;

    n = 0;
    while (!(rdy_o[0] && rdy_o[1]) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL idle_wait got=busy exp=idle");
    end

    build_model(a, b, c, col);
    for (int d = 0; d < 2; d++) t0[d] = int'(tiles_o[d]);

    ready_in = 1'b0; v0_in = a; v1_in = b; v2_in = c; color_in = col; tri_vld_in = 1'b1;
    @(posedge clk); #1;
    // SETUP cycle: offer a junk triangle that must not be captured.
    v0_in = ~a; v1_in = ~b; v2_in = ~c; color_in = ~col;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy_o[d] !== 1'b0 || busy_o[d] !== 1'b1 || vld_o[d] !== 1'b0) begin
        failures++;
        $display("FAIL setup_state dut%0d got rdy=%b busy=%b vld=%b exp 0 1 0",
                 d, rdy_o[d], busy_o[d], vld_o[d]);
      end
    end
    @(posedge clk); #1;
    tri_vld_in = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (v0_o[d] !== a || v1_o[d] !== b || v2_o[d] !== c) begin
        failures++;
        $display("FAIL capture dut%0d got=%h/%h/%h exp=%h/%h/%h",
                 d, v0_o[d], v1_o[d], v2_o[d], a, b, c);
      end
      checks++;
      if (vld_o[d] !== (exp_n[d] != 0) || rdy_o[d] !== (exp_n[d] == 0)) begin
        failures++;
        $display("FAIL first_beat_latency dut%0d got vld=%b rdy=%b exp vld=%b rdy=%b",
                 d, vld_o[d], rdy_o[d], exp_n[d] != 0, exp_n[d] == 0);
      end
      got[d] = 0; stalled_prev[d] = 1'b0; idle_next[d] = 1'b0; prev_meta[d] = 16'd0;
    end

    stall_cnt = 0;
    cyc = 0;
    while (cyc < 4000 && !(rdy_o[0] && rdy_o[1])) begin
      for (int d = 0; d < 2; d++) begin
        if (idle_next[d]) begin
          checks++;
          if (rdy_o[d] !== 1'b1 || vld_o[d] !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_last dut%0d got rdy=%b vld=%b exp 1 0",
                     d, rdy_o[d], vld_o[d]);
          end
          idle_next[d] = 1'b0;
        end
        if (stalled_prev[d]) begin
          checks++;
          if (vld_o[d] !== 1'b1 || meta_o[d] !== prev_meta[d]) begin
            failures++;
            $display("FAIL hold_stable dut%0d got vld=%b meta=%h exp vld=1 meta=%h",
                     d, vld_o[d], meta_o[d], prev_meta[d]);
          end
        end
      end

      r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vld_o[0] && got[0] == stall_at && stall_cnt < stall_len) begin
        r = 1'b0;
        stall_cnt++;
      end
      ready_in = r;

      for (int d = 0; d < 2; d++) begin
        if (vld_o[d]) begin
          checks++;
          if (got[d] >= exp_n[d]) begin
            failures++;
            $display("FAIL extra_beat dut%0d got meta=%h exp no beat", d, meta_o[d]);
          end else if (meta_o[d] !== exp_meta[d][got[d]] ||
                       v0_o[d] !== a || v1_o[d] !== b || v2_o[d] !== c) begin
            failures++;
            $display("FAIL beat dut%0d idx=%0d got meta=%h v0=%h exp meta=%h v0=%h",
                     d, got[d], meta_o[d], v0_o[d], exp_meta[d][got[d]], a);
          end
          if (r) begin
            got[d]++;
            if (got[d] == exp_n[d]) idle_next[d] = 1'b1;
            stalled_prev[d] = 1'b0;
          end else begin
            stalled_prev[d] = 1'b1;
            prev_meta[d] = meta_o[d];
          end
        end else begin
          stalled_prev[d] = 1'b0;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    ready_in = 1'b0;

    checks++;
    if (cyc >= 4000) begin
      failures++;
      $display("FAIL beat_timeout got=%0d cycles exp<4000", cyc);
    end
    for (int d = 0; d < 2; d++) begin
      if (idle_next[d]) begin
        checks++;
        if (rdy_o[d] !== 1'b1 || vld_o[d] !== 1'b0) begin
          failures++;
          $display("FAIL idle_after_last dut%0d got rdy=%b vld=%b exp 1 0",
                   d, rdy_o[d], vld_o[d]);
        end
      end
      checks++;
      if (got[d] != exp_n[d]) begin
        failures++;
        $display("FAIL beat_count dut%0d got=%0d exp=%0d", d, got[d], exp_n[d]);
      end
      checks++;
      if (tiles_o[d] !== 16'(t0[d] + exp_n[d])) begin
        failures++;
        $display("FAIL tiles_sent dut%0d got=%0d exp=%0d", d, tiles_o[d],
                 16'(t0[d] + exp_n[d]));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tri_vld_in = 1'b0; ready_in = 1'b0;
    v0_in = 28'd0; v1_in = 28'd0; v2_in = 28'd0; color_in = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdy_o[d] !== 1'b1 || vld_o[d] !== 1'b0 || busy_o[d] !== 1'b0 ||
          tiles_o[d] !== 16'd0 || meta_o[d] !== 16'd0 || v0_o[d] !== 28'd0 ||
          v1_o[d] !== 28'd0 || v2_o[d] !== 28'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d got rdy=%b vld=%b busy=%b tiles=%h meta=%h",
                 d, rdy_o[d], vld_o[d], busy_o[d], tiles_o[d], meta_o[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_tile();
    run_tri(vtx(10, 10, 0), vtx(20, 10, 0), vtx(10, 20, 0), 4'd5, -1, 0, 1'b0);
  endtask

  task automatic test_span_2x2();
    run_tri(vtx(20, 20, 0), vtx(40, 20, 0), vtx(20, 40, 0), 4'd3, -1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_tri(vtx(20, 20, 0), vtx(40, 20, 0), vtx(20, 40, 0), 4'd3, 1, 3, 1'b0);
  endtask

  task automatic test_clamp_offscreen();
    run_tri(vtx(600, 460, 7), vtx(1000, 470, 8), vtx(620, 1000, 9), 4'd9, -1, 0, 1'b0);
    run_tri(vtx(700, 10, 0), vtx(900, 300, 0), vtx(1023, 100, 0), 4'd2, -1, 0, 1'b0);
    run_tri(vtx(10, 480, 0), vtx(300, 700, 0), vtx(100, 1023, 0), 4'd2, -1, 0, 1'b0);
  endtask

  task automatic test_degenerate();
    run_tri(vtx(0, 0, 0), vtx(64, 64, 0), vtx(128, 128, 0), 4'd1, -1, 0, 1'b0);
  endtask

  task automatic test_vertex_order();
    logic [27:0] a, b, c;
    a = vtx($urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 255));
    b = vtx($urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 255));
    c = vtx($urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 255));
    run_tri(a, b, c, 4'd6, -1, 0, 1'b0);
    run_tri(c, a, b, 4'd6, -1, 0, 1'b0);
    run_tri(b, c, a, 4'd6, 0, 2, 1'b1);
  endtask

  task automatic test_reset_mid_emit();
    ready_in = 1'b1;
    v0_in = vtx(20, 20, 0); v1_in = vtx(40, 20, 0); v2_in = vtx(20, 40, 0);
    color_in = 4'd3; tri_vld_in = 1'b1;
    @(posedge clk); #1;
    tri_vld_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (vld_o[d] !== 1'b1 || meta_o[d] !== 16'h3001) begin
        failures++;
        $display("FAIL pre_reset_beat2 dut%0d got vld=%b meta=%h exp vld=1 meta=3001",
                 d, vld_o[d], meta_o[d]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (vld_o[d] !== 1'b0 || tiles_o[d] !== 16'd0 || rdy_o[d] !== 1'b1 ||
          busy_o[d] !== 1'b0) begin
        failures++;
        $display("FAIL mid_reset dut%0d got vld=%b tiles=%0d rdy=%b busy=%b exp 0 0 1 0",
                 d, vld_o[d], tiles_o[d], rdy_o[d], busy_o[d]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (vld_o[d] !== 1'b0 || tiles_o[d] !== 16'd0) begin
          failures++;
          $display("FAIL post_reset_quiet dut%0d got vld=%b tiles=%0d exp 0 0",
                   d, vld_o[d], tiles_o[d]);
        end
      end
    end
    ready_in = 1'b0;
    run_tri(vtx(20, 20, 0), vtx(40, 20, 0), vtx(20, 40, 0), 4'd3, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [27:0] a, b, c;
    int bx, by;
    for (int i = 0; i < 25; i++) begin
      bx = $urandom_range(0, 700);
      by = $urandom_range(0, 520);
      a = vtx(bx + $urandom_range(0, 127), by + $urandom_range(0, 127), $urandom_range(0, 255));
      b = vtx(bx + $urandom_range(0, 127), by + $urandom_range(0, 127), $urandom_range(0, 255));
      c = (i % 5 == 4) ? b :
          vtx(bx + $urandom_range(0, 127), by + $urandom_range(0, 127), $urandom_range(0, 255));
      run_tri(a, b, c, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
              $urandom_range(0, 4), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_span_2x2();
    test_backpressure();
    test_clamp_offscreen();
    test_degenerate();
    test_vertex_order();
    test_reset_mid_emit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
